lcd_bus_arbiter: RTL
====================

Name: lcd_bus_arbiter

Overview:
- Shares the single HD44780-style 8-bit LCD bus between two command/data requesters, e.g. an init sequencer and a result/text writer.
- Each accepted transfer is executed with correct RS/DATA setup, E pulse width, hold and post-command wait, so requesters no longer hand-code count-indexed timing.
- Sits between the LCD text/number formatting logic and the board pins. Drives LCD_RS, LCD_RW, LCD_E and DATA directly.

Parameters:
- SETUP_CYC, 100: cycles RS/DATA are stable before E rises (5 us at 20 MHz); must be ≥1.
- PULSE_CYC, 200: cycles E is held high; must be ≥1.
- HOLD_CYC, 20: cycles RS/DATA are held after E falls; must be ≥1.
- WAIT_CYC, 1000: post-transfer busy wait for normal commands and data; must be ≥1.
- LONG_WAIT_CYC, 40000: post-transfer wait for clear/home, i.e. RS=0 and data ≤ 8'h03; must be ≥1.
- CNT_W, 16: phase counter width; must hold the largest of the cycle parameters.

Ports:
- clk, in, 1: system clock (20 MHz on board).
- rst, in, 1: asynchronous, active-high reset.
- req0, in, 1: requester 0 transfer request; level, held until ack0.
- rs0, in, 1: requester 0 register select (0 = command, 1 = data).
- data0, in, 8: requester 0 byte.
- ack0, out, 1: one-cycle pulse; request 0 accepted and its rs0/data0 latched.
- done0, out, 1: one-cycle pulse; requester 0 transfer incl. wait complete.
- req1, rs1, data1, ack1, done1: same as above for requester 1.
- LCD_RS, out, 1: registered register select to the LCD.
- LCD_RW, out, 1: registered, constant 0 (write only).
- LCD_E, out, 1: registered enable strobe.
- DATA, out, 8: registered data bus to the LCD.
- busy, out, 1: high in every state except IDLE.

Behaviour:
- Reset (async, takes effect immediately): state=IDLE; LCD_E=0, LCD_RS=0, LCD_RW=0, DATA=8'h00; ack*, done*, busy=0; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE → SETUP → PULSE → HOLD → WAIT → IDLE.
- IDLE: samples req0/req1 each cycle.
  - If exactly one is high, grant it.
  - If both are high, grant the one ≠ last_grant (round-robin).
  - On the grant edge: latch rs/data into LCD_RS/DATA, record owner, update last_grant, pulse ack of owner in the following cycle, enter SETUP, load counter.
- SETUP: LCD_E=0 for exactly SETUP_CYC cycles.
- PULSE: LCD_E=1 for exactly PULSE_CYC cycles.
- HOLD: LCD_E=0 for HOLD_CYC cycles. LCD_RS/DATA are unchanged from grant through the end of HOLD.
- WAIT: lasts LONG_WAIT_CYC cycles if latched RS=0 and latched data ≤ 8'h03, else WAIT_CYC. LCD_E=0; LCD_RS/DATA keep their last value.
- On the last WAIT cycle: pulse done of owner for one cycle and go to IDLE. busy falls with the IDLE entry.
- The first new grant is possible in the first IDLE cycle. The minimum idle gap between back-to-back transfers is 1 cycle.
- Requests are only sampled in IDLE.
  - A req raised while busy waits.
  - A req dropped before its ack is simply not served, with no side effects.
  - rs/data changes after ack have no effect.
- Counter: loads param−1 on phase entry, decrements to 0, and the phase ends at 0. No wrap-around; the counter never underflows.
- ack and done never assert for the non-owner. ack0/ack1 are never high in the same cycle.
- Reset mid-transfer (any state): E drops at once, no done is issued, last_grant returns to 1, and the pending request is re-arbitrated after reset.

Test Plan (SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=1, WAIT_CYC=4, LONG_WAIT_CYC=10):
- Single write: req0=1, rs0=1, data0=8'h48.
  - ack0 one cycle after the grant edge; LCD_RS=1, DATA=8'h48.
  - LCD_E high exactly 3 cycles, starting 2 cycles after grant.
  - done0 pulses 4 WAIT cycles after HOLD; busy high from grant to done.
- Long wait: req1 with rs1=0, data1=8'h01 → WAIT lasts 10 cycles. Repeat with data1=8'h38 → WAIT lasts 4 cycles.
- Contention after reset: req0=req1=1 held continuously.
  - Grants alternate 0,1,0,1 with one IDLE cycle between transfers.
  - Each ack precedes the matching done; no cross-owner pulses.
- Withdrawal: raise req1 during a req0 transfer, drop it before that transfer's done → no ack1/done1, bus returns to IDLE.
- Data stability: change data0 to 8'hFF right after ack0 → DATA keeps the latched byte through HOLD, and the next transfer uses 8'hFF.
- Reset in PULSE: assert rst while LCD_E=1 → LCD_E=0 and busy=0 in the same cycle, no done0; requester 0 wins the first grant after rst releases.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter
//   Shares one HD44780-style 8-bit LCD write bus between two requesters.
//   Each accepted transfer runs RS/DATA setup, an E pulse, a hold phase and a
//   post-command busy wait. The wait is long for clear/home commands
//   (RS=0, data <= 8'h03) and short otherwise.
//   Simultaneous requests are granted round-robin. After reset, requester 0
//   wins the first tie.
//
// Ports
//   clk, rst             : clock and asynchronous active-high reset
//   req0/rs0/data0       : requester 0 level request, register select, byte
//   ack0                 : 1-cycle pulse, request 0 accepted (rs0/data0 latched)
//   done0                : 1-cycle pulse in the last wait cycle of transfer 0
//   req1/rs1/data1/ack1/done1 : same for requester 1
//   LCD_RS, LCD_RW, LCD_E, DATA : registered LCD pins (LCD_RW is tied to 0)
//   busy                 : high whenever a transfer is in progress (not IDLE)
module lcd_bus_arbiter #(
  parameter int SETUP_CYC     = 100,
  parameter int PULSE_CYC     = 200,
  parameter int HOLD_CYC      = 20,
  parameter int WAIT_CYC      = 1000,
  parameter int LONG_WAIT_CYC = 40000,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  output logic       done0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       done1,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] DATA,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  // Phase counters are loaded with length-1 and the phase ends when they reach 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LWAIT_LD = CNT_W'(LONG_WAIT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             e_q, e_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;

  logic             grant_vld;
  logic             grant_sel;
  logic             long_wait;

  // With both requesters asking, serve the one that was not served last.
  assign grant_vld = req0 | req1;
  assign grant_sel = (req0 && req1) ? ~last_grant_q : req1;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign long_wait = !rs_q && (data_q <= 8'h03);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rs_d         = rs_q;
    data_d       = data_q;
    e_d          = e_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d      = S_SETUP;
          cnt_d        = SETUP_LD;
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
          rs_d         = grant_sel ? rs1 : rs0;
          data_d       = grant_sel ? data1 : data0;
          ack0_d       = ~grant_sel;
          ack1_d       = grant_sel;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LD;
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = long_wait ? LWAIT_LD : WAIT_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        e_d     = 1'b0;
      end
    endcase

    // done is registered so that it is high exactly in the last WAIT cycle.
    if (state_d == S_WAIT && cnt_d == '0) begin
      done0_d = ~owner_q;
      done1_d = owner_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
      e_q          <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      e_q          <= e_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign LCD_RS = rs_q;
  assign LCD_RW = 1'b0;
  assign LCD_E  = e_q;
  assign DATA   = data_q;
  assign busy   = (state_q != S_IDLE);

endmodule
